// File: rtl/cv32e40x_xif_aes_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : cv32e40x_xif_aes_sequencer
// Brief   : In-order commit/kill scoreboard pairing AES32 FU results with XIF
//           issue/commit state and driving a one-entry XIF result register.
// Revision: 1.0
// ============================================================================
module cv32e40x_xif_aes_sequencer #(
   parameter int X_ID_WIDTH = 4,
   parameter int DEPTH      = 5
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         acc_valid_i,
   input  logic [X_ID_WIDTH-1:0]        acc_id_i,
   input  logic [4:0]                   acc_rd_i,
   output logic                         acc_ready_o,
   input  logic                         commit_valid_i,
   input  logic [X_ID_WIDTH-1:0]        commit_id_i,
   input  logic                         commit_kill_i,
   input  logic                         fu_valid_i,
   input  logic [X_ID_WIDTH-1:0]        fu_id_i,
   input  logic [31:0]                  fu_data_i,
   output logic                         fu_ready_o,
   output logic                         result_valid_o,
   output logic [X_ID_WIDTH-1:0]        result_id_o,
   output logic [4:0]                   result_rd_o,
   output logic [31:0]                  result_data_o,
   input  logic                         result_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
   output logic                         err_o
);

   localparam int C_PTR_W = $clog2(DEPTH);
   localparam int C_CNT_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      ST_FREE      = 2'b00,
      ST_PENDING   = 2'b01,
      ST_COMMITTED = 2'b10,
      ST_KILLED    = 2'b11
   } entry_st_e;

   entry_st_e               r_st [DEPTH];
   logic [X_ID_WIDTH-1:0]   r_id [DEPTH];
   logic [4:0]              r_rd [DEPTH];
   logic [C_PTR_W-1:0]      r_head;
   logic [C_PTR_W-1:0]      r_tail;
   logic [C_CNT_W-1:0]      r_count;

   logic                    r_result_valid;
   logic [X_ID_WIDTH-1:0]   r_result_id;
   logic [4:0]              r_result_rd;
   logic [31:0]             r_result_data;
   logic                    r_err;

   logic [DEPTH-1:0]        w_cam_hit;
   logic                    w_cam_found;
   logic [C_PTR_W-1:0]      w_cam_idx;
   entry_st_e               w_head_st;
   logic                    w_sb_empty;
   logic                    w_alloc;
   logic                    w_fu_ready;
   logic                    w_free;
   logic                    w_load;
   logic                    w_fu_err;

   function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
      return (p == C_PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Only registered PENDING entries are searched, so a same-cycle allocation
   // (still FREE at the tail) can never match.
   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_cam
         assign w_cam_hit[g] = (r_st[g] == ST_PENDING) && (r_id[g] == commit_id_i);
      end
   endgenerate

   always_comb begin
      w_cam_found = 1'b0;
      w_cam_idx   = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (w_cam_hit[i]) begin
            w_cam_found = 1'b1;
            w_cam_idx   = C_PTR_W'(i);
         end
      end
   end

   assign w_head_st   = r_st[r_head];
   assign w_sb_empty  = (r_count == '0);
   assign acc_ready_o = (r_count < C_CNT_W'(DEPTH)) && !rst_i;
   assign w_alloc     = acc_valid_i && acc_ready_o;

   always_comb begin
      w_fu_ready = 1'b0;
      w_free     = 1'b0;
      w_load     = 1'b0;
      w_fu_err   = 1'b0;
      if (fu_valid_i && !rst_i) begin
         if (w_sb_empty) begin
            w_fu_ready = 1'b1;
            w_fu_err   = 1'b1;
         end else begin
            case (w_head_st)
               ST_KILLED: begin
                  w_fu_ready = 1'b1;
                  w_free     = 1'b1;
               end
               ST_COMMITTED: begin
                  if (!r_result_valid || result_ready_i) begin
                     w_fu_ready = 1'b1;
                     w_free     = 1'b1;
                     w_load     = 1'b1;
                  end
               end
               default: ;
            endcase
            if (w_free && (fu_id_i != r_id[r_head])) begin
               w_fu_err = 1'b1;
            end
         end
      end
   end

   assign fu_ready_o = w_fu_ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_st[i] <= ST_FREE;
            r_id[i] <= '0;
            r_rd[i] <= '0;
         end
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_result_valid <= 1'b0;
         r_result_id    <= '0;
         r_result_rd    <= '0;
         r_result_data  <= '0;
         r_err          <= 1'b0;
      end else begin
         // Commit target, freed head and allocated tail are always distinct:
         // the head is never PENDING and the tail is always FREE.
         if (commit_valid_i && w_cam_found) begin
            r_st[w_cam_idx] <= commit_kill_i ? ST_KILLED : ST_COMMITTED;
         end
         if (w_free) begin
            r_st[r_head] <= ST_FREE;
            r_head       <= ptr_inc(r_head);
         end
         if (w_alloc) begin
            r_st[r_tail] <= ST_PENDING;
            r_id[r_tail] <= acc_id_i;
            r_rd[r_tail] <= acc_rd_i;
            r_tail       <= ptr_inc(r_tail);
         end
         r_count <= r_count + C_CNT_W'(w_alloc) - C_CNT_W'(w_free);

         if (w_load) begin
            r_result_valid <= 1'b1;
            r_result_id    <= fu_id_i;
            r_result_rd    <= r_rd[r_head];
            r_result_data  <= fu_data_i;
         end else if (result_ready_i) begin
            r_result_valid <= 1'b0;
         end

         if ((commit_valid_i && !w_cam_found) || w_fu_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign result_valid_o = r_result_valid;
   assign result_id_o    = r_result_id;
   assign result_rd_o    = r_result_rd;
   assign result_data_o  = r_result_data;
   assign outstanding_o  = r_count;
   assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40x_xif_aes_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cv32e40x_xif_aes_sequencer
// Brief   : Directed and randomized bench against a queue-based scoreboard model.
// Revision: 1.0
// ============================================================================
module tb_cv32e40x_xif_aes_sequencer;

   localparam int X_ID_WIDTH = 4;
   localparam int DEPTH      = 5;
   localparam int ST_PEND    = 1;
   localparam int ST_COMM    = 2;
   localparam int ST_KILL    = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        acc_valid;
   logic [3:0]  acc_id;
   logic [4:0]  acc_rd;
   logic        acc_ready;
   logic        commit_valid;
   logic [3:0]  commit_id;
   logic        commit_kill;
   logic        fu_valid;
   logic [3:0]  fu_id;
   logic [31:0] fu_data;
   logic        fu_ready;
   logic        result_valid;
   logic [3:0]  result_id;
   logic [4:0]  result_rd;
   logic [31:0] result_data;
   logic        result_ready;
   logic [2:0]  outstanding;
   logic        err;

   always #5 clk = ~clk;

   cv32e40x_xif_aes_sequencer #(
      .X_ID_WIDTH (X_ID_WIDTH),
      .DEPTH      (DEPTH)
   ) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .acc_valid_i    (acc_valid),
      .acc_id_i       (acc_id),
      .acc_rd_i       (acc_rd),
      .acc_ready_o    (acc_ready),
      .commit_valid_i (commit_valid),
      .commit_id_i    (commit_id),
      .commit_kill_i  (commit_kill),
      .fu_valid_i     (fu_valid),
      .fu_id_i        (fu_id),
      .fu_data_i      (fu_data),
      .fu_ready_o     (fu_ready),
      .result_valid_o (result_valid),
      .result_id_o    (result_id),
      .result_rd_o    (result_rd),
      .result_data_o  (result_data),
      .result_ready_i (result_ready),
      .outstanding_o  (outstanding),
      .err_o          (err)
   );

   typedef struct { logic [3:0] id; logic [4:0] rd; int st; } ent_t;
   typedef struct { logic [3:0] id; logic [31:0] data; } fu_t;

   ent_t        sb[$];      // outstanding instructions, oldest first
   fu_t         fuq[$];     // results the FU will return, in order
   logic        m_rv    = 1'b0;
   logic [3:0]  m_rid   = '0;
   logic [4:0]  m_rrd   = '0;
   logic [31:0] m_rdata = '0;
   logic        m_err   = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_acc_ready();
      return !rst && (sb.size() < DEPTH);
   endfunction

   function automatic bit m_consume();
      if (rst || !fu_valid) return 1'b0;
      if (sb.size() == 0) return 1'b1;
      if (sb[0].st == ST_KILL) return 1'b1;
      if (sb[0].st == ST_COMM) return !m_rv || result_ready;
      return 1'b0;
   endfunction

   function automatic bit id_in_sb(input logic [3:0] id);
      foreach (sb[i]) if (sb[i].id == id) return 1'b1;
      return 1'b0;
   endfunction

   task automatic idle();
      acc_valid    = 1'b0; acc_id    = '0; acc_rd = '0;
      commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
      fu_valid     = 1'b0; fu_id     = '0; fu_data = '0;
      result_ready = 1'b1;
   endtask

   // Compare every output mid-cycle, then advance the model across the edge.
   task automatic step();
      bit take, acc, freed, load;
      int ci;
      #4;
      check_eq("acc_ready", acc_ready, m_acc_ready());
      check_eq("fu_ready", fu_ready, m_consume());
      check_eq("result_valid", result_valid, m_rv);
      if (m_rv) begin
         check_eq("result_id", result_id, m_rid);
         check_eq("result_rd", result_rd, m_rrd);
         check_eq("result_data", result_data, m_rdata);
      end
      check_eq("outstanding", outstanding, sb.size());
      check_eq("err", err, m_err);
      take = m_consume();
      acc  = acc_valid && m_acc_ready();
      if (rst) begin
         sb.delete();
         fuq.delete();
         m_rv = 1'b0; m_rid = '0; m_rrd = '0; m_rdata = '0; m_err = 1'b0;
      end else begin
         ci = -1;
         if (commit_valid) begin
            foreach (sb[i]) if (ci < 0 && sb[i].st == ST_PEND && sb[i].id == commit_id) ci = i;
            if (ci < 0) m_err = 1'b1;
         end
         freed = 1'b0;
         load  = 1'b0;
         if (take) begin
            if (sb.size() == 0) m_err = 1'b1;
            else begin
               freed = 1'b1;
               load  = (sb[0].st == ST_COMM);
               if (fu_id != sb[0].id) m_err = 1'b1;
            end
         end
         if (load) begin
            m_rv = 1'b1; m_rid = fu_id; m_rrd = sb[0].rd; m_rdata = fu_data;
         end else if (result_ready) begin
            m_rv = 1'b0;
         end
         if (ci >= 0) sb[ci].st = commit_kill ? ST_KILL : ST_COMM;
         if (freed) void'(sb.pop_front());
         if (acc) sb.push_back('{acc_id, acc_rd, ST_PEND});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wrap_round(input int base);
      for (int k = 0; k < DEPTH; k++) begin
         idle(); acc_valid = 1'b1; acc_id = 4'(base + k); acc_rd = 5'(base + k + 16); step();
      end
      idle(); acc_valid = 1'b1; acc_id = 4'd15;
      #1;
      check_eq("full_acc_ready", acc_ready, 0);
      check_eq("full_count", outstanding, DEPTH);
      step();
      for (int k = 0; k < DEPTH; k++) begin
         idle(); commit_valid = 1'b1; commit_id = 4'(base + k); step();
      end
      for (int k = 0; k < DEPTH; k++) begin
         idle(); fu_valid = 1'b1; fu_id = 4'(base + k); fu_data = 32'(base + k) | 32'hC0DE_0000; step();
         check_eq("wrap_order_id", result_id, base + k);
         check_eq("wrap_order_rd", result_rd, base + k + 16);
      end
      idle(); step();
   endtask

   task automatic run_random(input int cycles);
      int  pend[$];
      bit  took;
      for (int cyc = 0; cyc < cycles; cyc++) begin
         idle();
         pend.delete();
         result_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            acc_valid = 1'b1;
            do acc_id = 4'($urandom_range(0, 15)); while (id_in_sb(acc_id));
            acc_rd = 5'($urandom_range(0, 31));
         end
         foreach (sb[i]) if (sb[i].st == ST_PEND) pend.push_back(i);
         if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
            commit_valid = 1'b1;
            commit_id    = sb[pend[$urandom_range(0, pend.size()-1)]].id;
            commit_kill  = ($urandom_range(0, 3) == 0);
         end
         if (fuq.size() > 0 && $urandom_range(0, 3) != 0) begin
            fu_valid = 1'b1; fu_id = fuq[0].id; fu_data = fuq[0].data;
         end
         took = m_consume();
         if (acc_valid && m_acc_ready()) fuq.push_back('{acc_id, $urandom});
         step();
         if (took) void'(fuq.pop_front());
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_acc_ready", acc_ready, 0);
      step();
      rst = 1'b0;
      step();

      // Commit path
      acc_valid = 1'b1; acc_id = 4'd3; acc_rd = 5'd5; step();
      idle(); commit_valid = 1'b1; commit_id = 4'd3; step();
      idle(); result_ready = 1'b0; fu_valid = 1'b1; fu_id = 4'd3; fu_data = 32'hA5A5_0001; step();
      idle(); result_ready = 1'b0;
      check_eq("cp_valid", result_valid, 1);
      check_eq("cp_id", result_id, 3);
      check_eq("cp_rd", result_rd, 5);
      check_eq("cp_data", result_data, 32'hA5A5_0001);
      step();
      check_eq("cp_hold", result_valid, 1);
      result_ready = 1'b1; step();
      check_eq("cp_drained", result_valid, 0);
      check_eq("cp_count", outstanding, 0);

      // Kill path
      idle(); acc_valid = 1'b1; acc_id = 4'd1; acc_rd = 5'd1; step();
      acc_id = 4'd2; acc_rd = 5'd2; step();
      idle(); commit_valid = 1'b1; commit_id = 4'd1; commit_kill = 1'b1; step();
      idle(); commit_valid = 1'b1; commit_id = 4'd2; step();
      idle(); fu_valid = 1'b1; fu_id = 4'd1; fu_data = 32'h1111_1111; step();
      check_eq("kp_dropped", result_valid, 0);
      fu_id = 4'd2; fu_data = 32'h2222_2222; step();
      idle();
      check_eq("kp_valid", result_valid, 1);
      check_eq("kp_id", result_id, 2);
      check_eq("kp_err", err, 0);
      step();

      // Late commit
      acc_valid = 1'b1; acc_id = 4'd7; acc_rd = 5'd9; step();
      idle(); fu_valid = 1'b1; fu_id = 4'd7; fu_data = 32'h7777_0007;
      repeat (3) begin
         #1; check_eq("lc_stall", fu_ready, 0); step();
      end
      commit_valid = 1'b1; commit_id = 4'd7;
      #1; check_eq("lc_same_cycle", fu_ready, 0); step();
      commit_valid = 1'b0;
      #1; check_eq("lc_release", fu_ready, 1); step();
      idle();
      check_eq("lc_result_id", result_id, 7);
      check_eq("lc_result_data", result_data, 32'h7777_0007);
      step();

      // Full and wrap
      wrap_round(0);
      wrap_round(5);

      // Backpressure
      for (int k = 10; k < 13; k++) begin
         idle(); acc_valid = 1'b1; acc_id = 4'(k); acc_rd = 5'(k); step();
      end
      for (int k = 10; k < 13; k++) begin
         idle(); commit_valid = 1'b1; commit_id = 4'(k); step();
      end
      idle(); result_ready = 1'b0; fu_valid = 1'b1; fu_id = 4'd10; fu_data = 32'hB0; step();
      fu_id = 4'd11; fu_data = 32'hB1;
      repeat (2) begin
         #1;
         check_eq("bp_stall", fu_ready, 0);
         check_eq("bp_stable", result_data, 32'hB0);
         step();
      end
      result_ready = 1'b1; step();
      check_eq("bp_stream1", result_id, 11);
      fu_id = 4'd12; fu_data = 32'hB2; step();
      check_eq("bp_stream2", result_id, 12);
      fu_valid = 1'b0; step();
      check_eq("bp_done", result_valid, 0);
      check_eq("bp_count", outstanding, 0);

      // Randomized traffic from a clean state
      idle(); rst = 1'b1; step(); rst = 1'b0;
      run_random(1500);

      // Protocol error and reset mid-operation
      idle(); rst = 1'b1; step(); rst = 1'b0; step();
      for (int k = 13; k < 16; k++) begin
         idle(); acc_valid = 1'b1; acc_id = 4'(k); acc_rd = 5'(k); step();
      end
      idle(); commit_valid = 1'b1; commit_id = 4'd13; step();
      idle(); result_ready = 1'b0; fu_valid = 1'b1; fu_id = 4'd13; fu_data = 32'hD00D; step();
      idle(); result_ready = 1'b0; commit_valid = 1'b1; commit_id = 4'd9; step();
      idle(); result_ready = 1'b0;
      check_eq("err_set", err, 1);
      check_eq("err_count_kept", outstanding, 2);
      check_eq("err_result_pending", result_valid, 1);
      rst = 1'b1;
      #1; check_eq("rst_acc_low", acc_ready, 0);
      step();
      check_eq("rst_result_valid", result_valid, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_count", outstanding, 0);
      rst = 1'b0;
      #1; check_eq("rst_acc_ready_after", acc_ready, 1);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
